// File: rtl/ad_pack_pkg.sv
// Shared helpers for the ad_pack / ad_upack_stream width converters:
// clog2, buffer sizing and unit selection.
package ad_pack_pkg;

  function automatic int ad_clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int ad_buf_units(input int i_w, input int o_w);
    return i_w + o_w;
  endfunction

  // Level must represent 0..BUF_U inclusive.
  function automatic int ad_level_w(input int i_w, input int o_w);
    return ad_clog2(i_w + o_w + 1);
  endfunction

  function automatic int ad_unit_lsb(input int k, input int unit_w);
    return k * unit_w;
  endfunction

endpackage

// File: rtl/ad_upack_stream.sv
// Unpacking width converter: I_W-unit input words to O_W-unit output words, lowest unit first.
// Output is a direct register slice; iready depends on the registered count only.
module ad_upack_stream
  import ad_pack_pkg::*;
#(
  parameter int I_W    = 6,
  parameter int O_W    = 4,
  parameter int UNIT_W = 8,
  localparam int LVL_W = ad_level_w(I_W, O_W)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [I_W*UNIT_W-1:0]   idata,
  input  logic                    ivalid,
  output logic                    iready,
  output logic [O_W*UNIT_W-1:0]   odata,
  output logic                    ovalid,
  input  logic                    oready,
  output logic [LVL_W-1:0]        level
);

  localparam int BUF_U = ad_buf_units(I_W, O_W);

  logic [LVL_W-1:0]          count_q;
  logic [LVL_W-1:0]          count_d;
  logic [LVL_W-1:0]          wofs;
  logic [BUF_U*UNIT_W-1:0]   buf_q;
  logic [BUF_U*UNIT_W-1:0]   buf_d;
  logic                      rst_done_q;
  logic                      push;
  logic                      pop;

  assign iready = rst_done_q && (count_q <= LVL_W'(O_W));
  assign ovalid = (count_q >= LVL_W'(O_W));
  assign push   = ivalid && iready;
  assign pop    = ovalid && oready;
  assign odata  = buf_q[O_W*UNIT_W-1:0];
  assign level  = count_q;

  // On a simultaneous pop the insert lands after the shift, O_W units lower.
  assign wofs = pop ? (count_q - LVL_W'(O_W)) : count_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + LVL_W'(I_W);
      2'b01:   count_d = count_q - LVL_W'(O_W);
      2'b11:   count_d = count_q + LVL_W'(I_W) - LVL_W'(O_W);
      default: count_d = count_q;
    endcase
  end

  for (genvar j = 0; j < BUF_U; j++) begin : g_slot
    logic [UNIT_W-1:0] shift_val;
    logic [UNIT_W-1:0] slot_d;

    // Top slots refill with zeros so stale or X units never reach odata.
    if (j + O_W < BUF_U) begin : g_up
      assign shift_val = buf_q[(j+O_W)*UNIT_W +: UNIT_W];
    end else begin : g_top
      assign shift_val = '0;
    end

    always_comb begin
      slot_d = buf_q[j*UNIT_W +: UNIT_W];
      if (pop) begin
        slot_d = shift_val;
      end
      for (int k = 0; k < I_W; k++) begin
        if (push && ((int'(wofs) + k) == j)) begin
          slot_d = idata[ad_unit_lsb(k, UNIT_W) +: UNIT_W];
        end
      end
    end

    assign buf_d[j*UNIT_W +: UNIT_W] = slot_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q    <= '0;
      buf_q      <= '0;
      rst_done_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      buf_q      <= buf_d;
      rst_done_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ad_upack_stream.sv
// Directed and randomized-handshake bench for ad_upack_stream at 6/4/8.
module tb_ad_upack_stream;

  localparam int I_W = 6;
  localparam int O_W = 4;
  localparam int UNIT_W = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [47:0] idata = '0;
  logic        ivalid = 1'b0;
  logic        iready;
  logic [31:0] odata;
  logic        ovalid;
  logic        oready = 1'b0;
  logic [3:0]  level;

  int n_checks = 0;
  int n_fail = 0;
  byte unsigned outq[$];
  byte unsigned vec[$];
  int  max_lvl = 0;
  bit  x_seen = 1'b0;
  bit  rnd_rdy = 1'b0;

  ad_upack_stream #(.I_W(I_W), .O_W(O_W), .UNIT_W(UNIT_W)) dut (
    .clk(clk), .resetn(resetn), .idata(idata), .ivalid(ivalid), .iready(iready),
    .odata(odata), .ovalid(ovalid), .oready(oready), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: values at the negedge are the ones the next posedge acts on.
  initial forever begin
    @(negedge clk);
    if (int'(level) > max_lvl) max_lvl = int'(level);
    if (ovalid === 1'b1 && $isunknown(odata)) x_seen = 1'b1;
    if (ovalid === 1'b1 && oready === 1'b1)
      for (int k = 0; k < O_W; k++) outq.push_back(odata[k*8 +: 8]);
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rdy) oready = 1'($urandom_range(1, 0));
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic send_word(input logic [47:0] w, input bit rnd, input string tag);
    bit done;
    done = 1'b0;
    idata = w;
    for (int g = 0; g < 400 && !done; g++) begin
      ivalid = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      @(negedge clk);
      done = ivalid && iready;
      @(posedge clk);
      #1;
    end
    ivalid = 1'b0;
    if (!done) chk({tag, "_push_timeout"}, 64'(done), 64'd1);
  endtask

  task automatic send_vec(input int first_word, input bit rnd, input string tag);
    logic [47:0] w;
    for (int i = first_word; i < vec.size() / I_W; i++) begin
      for (int k = 0; k < I_W; k++) w[k*8 +: 8] = vec[i*I_W + k];
      send_word(w, rnd, tag);
    end
  endtask

  task automatic drain_and_compare(input string tag);
    int bad;
    for (int g = 0; g < 5000 && outq.size() < vec.size(); g++) step();
    chk({tag, "_nbytes"}, 64'(outq.size()), 64'(vec.size()));
    bad = 0;
    for (int i = 0; i < vec.size(); i++)
      if (i >= outq.size() || outq[i] !== vec[i]) bad++;
    chk({tag, "_bad_bytes"}, 64'(bad), 64'd0);
  endtask

  initial begin
    // Reset values
    repeat (5) @(posedge clk);
    #1;
    chk("rst_ovalid", 64'(ovalid), 64'd0);
    chk("rst_iready", 64'(iready), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_odata", 64'(odata), 64'd0);
    resetn = 1'b1;
    chk("rel_iready_pre_edge", 64'(iready), 64'd0);
    step();
    chk("rel_iready_after_edge", 64'(iready), 64'd1);

    // Ordered data
    oready = 1'b1;
    idata = 48'h050403020100;
    ivalid = 1'b1;
    step();
    ivalid = 1'b0;
    chk("ord_odata0", 64'(odata), 64'h03020100);
    chk("ord_level6", 64'(level), 64'd6);
    chk("ord_ovalid", 64'(ovalid), 64'd1);
    step();
    chk("ord_level2", 64'(level), 64'd2);
    chk("ord_ovalid_low", 64'(ovalid), 64'd0);
    idata = 48'h0B0A09080706;
    ivalid = 1'b1;
    step();
    ivalid = 1'b0;
    chk("ord_odata1", 64'(odata), 64'h07060504);
    chk("ord_level8", 64'(level), 64'd8);
    step();
    chk("ord_odata2", 64'(odata), 64'h0B0A0908);
    chk("ord_level4", 64'(level), 64'd4);
    step();
    chk("ord_level0", 64'(level), 64'd0);

    // Backpressure: first word lands, second held while the sink stalls
    oready = 1'b0;
    vec.delete();
    for (int i = 0; i < 24; i++) vec.push_back(8'(8'h40 + i));
    outq.delete();
    idata = 48'h454443424140;
    ivalid = 1'b1;
    step();
    chk("bp_level", 64'(level), 64'd6);
    chk("bp_iready", 64'(iready), 64'd0);
    chk("bp_ovalid", 64'(ovalid), 64'd1);
    idata = 48'h4B4A49484746;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("bp_odata_stable", 64'(odata), 64'h43424140);
    end
    chk("bp_level_held", 64'(level), 64'd6);
    oready = 1'b1;
    send_vec(1, 1'b0, "bp");
    drain_and_compare("bp_drain");

    // Random handshakes: incremental vector, then random bytes
    max_lvl = 0;
    vec.delete();
    for (int i = 0; i < 1032; i++) vec.push_back(8'(i));
    outq.delete();
    rnd_rdy = 1'b1;
    send_vec(0, 1'b1, "inc");
    drain_and_compare("inc");
    rnd_rdy = 1'b0;
    vec.delete();
    for (int i = 0; i < 240; i++) vec.push_back(8'($urandom_range(255, 0)));
    outq.delete();
    rnd_rdy = 1'b1;
    send_vec(0, 1'b1, "rnd");
    drain_and_compare("rnd");
    rnd_rdy = 1'b0;
    step();
    oready = 1'b0;
    chk("stress_level_max_le10", 64'(max_lvl <= 10), 64'd1);
    chk("stress_no_x", 64'(x_seen), 64'd0);
    chk("stress_level_end", 64'(level), 64'd0);

    // Simultaneous push and pop at level 4
    idata = 48'h252423222120;
    ivalid = 1'b1;
    step();
    ivalid = 1'b0;
    oready = 1'b1;
    step();
    oready = 1'b0;
    chk("sim_level2", 64'(level), 64'd2);
    idata = 48'h2B2A29282726;
    ivalid = 1'b1;
    step();
    ivalid = 1'b0;
    chk("sim_odata_l8", 64'(odata), 64'h27262524);
    oready = 1'b1;
    step();
    chk("sim_level4", 64'(level), 64'd4);
    chk("sim_odata_l4", 64'(odata), 64'h2B2A2928);
    chk("sim_iready_at4", 64'(iready), 64'd1);
    idata = 48'h31302F2E2D2C;
    ivalid = 1'b1;
    step();
    ivalid = 1'b0;
    chk("sim_level6", 64'(level), 64'd6);
    chk("sim_odata_next", 64'(odata), 64'h2F2E2D2C);

    // Reset mid-stream with two units buffered
    step();
    oready = 1'b0;
    chk("mid_level2", 64'(level), 64'd2);
    chk("mid_odata_partial", 64'(odata), 64'h00003130);
    resetn = 1'b0;
    #1;
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_ovalid", 64'(ovalid), 64'd0);
    step();
    resetn = 1'b1;
    step();
    idata = 48'h151413121110;
    ivalid = 1'b1;
    step();
    ivalid = 1'b0;
    chk("mid_first_odata", 64'(odata), 64'h13121110);
    chk("mid_level6", 64'(level), 64'd6);
    oready = 1'b1;
    step();
    chk("mid_tail_odata", 64'(odata), 64'h00001514);
    chk("mid_tail_level", 64'(level), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
